vga_bitmap_window: RTL and testbench



---
 rtl/vga_bitmap_window.sv | 162 ++++++++++++++++
 tb/tb_vga_bitmap_window.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_bitmap_window.sv
// Overlays a 1-bpp ROM bitmap as a window on the sync generator's raster.
// Four-stage pipeline: window/index, ROM address, ROM wait, colour select.
module vga_bitmap_window #(
  parameter int H_ORIGIN     = 216,
  parameter int V_ORIGIN     = 27,
  parameter int IMG_W        = 128,
  parameter int IMG_H        = 128,
  parameter int SCALE_LOG2   = 0,
  parameter int ROM_AW       = 11,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       c1,
  input  logic [10:0]       c2,
  input  logic              frame_start,
  input  logic [9:0]        x_off,
  input  logic [9:0]        y_off,
  input  logic [2:0]        fg_color,
  input  logic [2:0]        bg_color,
  input  logic [1:0]        mode,
  input  logic [7:0]        rom_data,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [2:0]        rgb,
  output logic              in_window
);

  localparam int IW = $clog2(IMG_W);
  localparam int IH = $clog2(IMG_H);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [11:0]   WIN_W      = 12'(IMG_W << SCALE_LOG2);
  localparam logic [11:0]   WIN_H      = 12'(IMG_H << SCALE_LOG2);
  localparam logic [11:0]   H_BASE     = 12'(H_ORIGIN + 1);
  localparam logic [11:0]   V_BASE     = 12'(V_ORIGIN + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_TRANSP = 2'd3
  } mode_e;

  // Everything the colour stage needs, carried alongside each pixel so a
  // mid-frame shadow update never touches pixels already in flight.
  typedef struct packed {
    logic [2:0] fg;
    logic [2:0] bg;
    mode_e      mode;
    logic       phase;
  } render_t;

  logic [9:0]    xs, ys;
  render_t       sh;
  logic [BW-1:0] blink_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      xs        <= '0;
      ys        <= '0;
      sh        <= '0;
      blink_cnt <= '0;
    end else if (frame_start) begin
      xs       <= x_off;
      ys       <= y_off;
      sh.fg    <= fg_color;
      sh.bg    <= bg_color;
      sh.mode  <= mode_e'(mode);
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        sh.phase  <= ~sh.phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Window test at 12 bits: far edge is at most 2263, so nothing wraps.
  logic [11:0]   h_lo, h_hi, v_lo, v_hi, dx, dy;
  logic          win_act;
  logic [IW-1:0] ix_next;
  logic [IH-1:0] iy_next;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    h_lo    = H_BASE + {2'b00, xs};
    v_lo    = V_BASE + {2'b00, ys};
    h_hi    = h_lo + WIN_W - 12'd1;
    v_hi    = v_lo + WIN_H - 12'd1;
    dx      = {1'b0, c1} - h_lo;
    dy      = {1'b0, c2} - v_lo;
    win_act = ({1'b0, c1} >= h_lo) && ({1'b0, c1} <= h_hi) &&
              ({1'b0, c2} >= v_lo) && ({1'b0, c2} <= v_hi);
    ix_next = IW'(dx >> SCALE_LOG2);
    iy_next = IH'(dy >> SCALE_LOG2);
  end

  logic [IW-1:0] ix0;
  logic [IH-1:0] iy0;
  logic          valid0, valid1, valid2;
  logic [2:0]    bi1, bi2;
  render_t       rp0, rp1, rp2;

  always_ff @(posedge clk) begin
    if (rst) begin
      ix0      <= '0;
      iy0      <= '0;
      valid0   <= 1'b0;
      rp0      <= '0;
      rom_addr <= '0;
      bi1      <= '0;
      valid1   <= 1'b0;
      rp1      <= '0;
      bi2      <= '0;
      valid2   <= 1'b0;
      rp2      <= '0;
    end else begin
      valid0   <= win_act;
      ix0      <= win_act ? ix_next : '0;
      iy0      <= win_act ? iy_next : '0;
      rp0      <= sh;
      // Row-major byte address; IMG_W/8 is a power of 2, so concatenation is the multiply.
      rom_addr <= ROM_AW'({iy0, ix0[IW-1:3]});
      bi1      <= ix0[2:0];
      valid1   <= valid0;
      rp1      <= rp0;
      bi2      <= bi1;
      valid2   <= valid1;
      rp2      <= rp1;
    end
  end

  logic       pix;
  logic [2:0] rgb_next;

  always_comb begin
    pix      = rom_data[bi2];
    rgb_next = 3'b000;
    if (valid2) begin
      unique case (rp2.mode)
        MODE_NORMAL: rgb_next = pix ? rp2.fg : rp2.bg;
        MODE_INVERT: rgb_next = pix ? rp2.bg : rp2.fg;
        MODE_BLINK:  rgb_next = (rp2.phase || !pix) ? rp2.bg : rp2.fg;
        MODE_TRANSP: rgb_next = pix ? rp2.fg : 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb       <= 3'b000;
      in_window <= 1'b0;
    end else begin
      rgb       <= rgb_next;
      in_window <= valid2;
    end
  end

endmodule

// File: tb/tb_vga_bitmap_window.sv
// Bench for vga_bitmap_window: two instances (scale 1x with 2-frame blink,
// scale 2x with default blink) checked against an arithmetic raster model.
module tb_vga_bitmap_window;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] c1, c2;
  logic        frame_start;
  logic [9:0]  x_off, y_off;
  logic [2:0]  fg_color, bg_color;
  logic [1:0]  mode;

  logic [7:0]  rom_data0, rom_data1;
  logic [10:0] rom_addr0, rom_addr1;
  logic [2:0]  rgb0, rgb1;
  logic        inw0, inw1;

  logic [7:0]  rom0 [2048];
  logic [7:0]  rom1 [2048];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Synchronous ROMs: data follows the address by one clock.
  always @(posedge clk) rom_data0 <= rom0[rom_addr0];
  always @(posedge clk) rom_data1 <= rom1[rom_addr1];

  vga_bitmap_window #(.SCALE_LOG2(0), .BLINK_FRAMES(2)) u_dut0 (
    .clk(clk), .rst(rst), .c1(c1), .c2(c2), .frame_start(frame_start),
    .x_off(x_off), .y_off(y_off), .fg_color(fg_color), .bg_color(bg_color),
    .mode(mode), .rom_data(rom_data0), .rom_addr(rom_addr0), .rgb(rgb0),
    .in_window(inw0)
  );

  vga_bitmap_window #(.SCALE_LOG2(1)) u_dut1 (
    .clk(clk), .rst(rst), .c1(c1), .c2(c2), .frame_start(frame_start),
    .x_off(x_off), .y_off(y_off), .fg_color(fg_color), .bg_color(bg_color),
    .mode(mode), .rom_data(rom_data1), .rom_addr(rom_addr1), .rgb(rgb1),
    .in_window(inw1)
  );

  typedef struct packed {
    logic [2:0]  rgb;
    logic        inw;
    logic [31:0] addr;
  } exp_t;

  exp_t q0[$], q1[$];
  int   aq0[$], aq1[$];

  // Model view of the frame-latched settings.
  int         m_xs, m_ys, m_nfs;
  logic [2:0] m_fg, m_bg;
  logic [1:0] m_mode;

  function automatic exp_t ref_pixel(input int s, input int blink, input int c1v, input int c2v);
    exp_t       e;
    int         col, row, px, py, bitn;
    logic [7:0] b;
    logic       pix, ph;
    e   = '0;
    col = c1v - 216 - m_xs;
    row = c2v - 27 - m_ys;
    if (col >= 1 && col <= (128 << s) && row >= 1 && row <= (128 << s)) begin
      px     = (col - 1) / (1 << s);
      py     = (row - 1) / (1 << s);
      e.addr = 32'(py * 16 + px / 8);
      bitn   = px % 8;
      b      = (s == 0) ? rom0[e.addr] : rom1[e.addr];
      pix    = b[bitn];
      ph     = ((m_nfs / blink) % 2) == 1;
      e.inw  = 1'b1;
      case (m_mode)
        2'd0:    e.rgb = pix ? m_fg : m_bg;
        2'd1:    e.rgb = pix ? m_bg : m_fg;
        2'd2:    e.rgb = ph ? m_bg : (pix ? m_fg : m_bg);
        default: e.rgb = pix ? m_fg : 3'b000;
      endcase
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel clock: drive inputs, update the model, then compare the
  // outputs that belong to the pixel driven 3 steps (rgb) or 1 step (addr) ago.
  task automatic step(input int c1v, input int c2v, input bit fs, input bit rs);
    exp_t e0, e1;
    c1          = 11'(c1v);
    c2          = 11'(c2v);
    frame_start = fs;
    rst         = rs;
    if (rs) begin
      q0.delete(); q1.delete(); aq0.delete(); aq1.delete();
      repeat (4) begin q0.push_back('0); q1.push_back('0); end
      repeat (2) begin aq0.push_back(0); aq1.push_back(0); end
      m_xs = 0; m_ys = 0; m_fg = '0; m_bg = '0; m_mode = '0; m_nfs = 0;
    end else begin
      e0 = ref_pixel(0, 2, c1v, c2v);
      e1 = ref_pixel(1, 30, c1v, c2v);
      q0.push_back(e0);
      q1.push_back(e1);
      aq0.push_back(int'(e0.addr));
      aq1.push_back(int'(e1.addr));
      if (fs) begin
        m_xs = int'(x_off); m_ys = int'(y_off);
        m_fg = fg_color; m_bg = bg_color; m_mode = mode;
        m_nfs++;
      end
    end
    @(posedge clk);
    #1;
    if (q0.size() == 4) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      check("rgb_s0", 32'(rgb0), 32'(e0.rgb));
      check("inw_s0", 32'(inw0), 32'(e0.inw));
      check("rgb_s1", 32'(rgb1), 32'(e1.rgb));
      check("inw_s1", 32'(inw1), 32'(e1.inw));
    end
    if (aq0.size() == 2) begin
      check("addr_s0", 32'(rom_addr0), 32'(aq0.pop_front()));
      check("addr_s1", 32'(rom_addr1), 32'(aq1.pop_front()));
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      rom0[i] = 8'($urandom);
      rom1[i] = 8'($urandom);
    end
    rom0[0]    = 8'h01;
    rom1[0]    = 8'h01;
    rom0[2047] = 8'h80;

    x_off = '0; y_off = '0; fg_color = 3'd7; bg_color = 3'd0; mode = 2'd0;
    repeat (4) step(0, 0, 1'b0, 1'b1);
    check("reset_rgb", 32'(rgb0), 32'd0);
    check("reset_inw", 32'(inw0), 32'd0);
    check("reset_addr", 32'(rom_addr0), 32'd0);
    step(0, 0, 1'b1, 1'b0);

    // Default geometry, first pixels and boundaries.
    step(217, 28, 1'b0, 1'b0);
    step(218, 28, 1'b0, 1'b0);
    check("addr_217", 32'(rom_addr0), 32'd0);
    check("addr_217_x2", 32'(rom_addr1), 32'd0);
    step(219, 28, 1'b0, 1'b0);
    check("addr_218_x2", 32'(rom_addr1), 32'd0);
    step(216, 28, 1'b0, 1'b0);
    check("rgb_217", 32'(rgb0), 32'd7);
    check("inw_217", 32'(inw0), 32'd1);
    check("rgb_217_x2", 32'(rgb1), 32'd7);
    step(345, 28, 1'b0, 1'b0);
    check("rgb_218", 32'(rgb0), 32'd0);
    check("inw_218", 32'(inw0), 32'd1);
    check("rgb_218_x2", 32'(rgb1), 32'd7);
    step(217, 27, 1'b0, 1'b0);
    check("rgb_219_x2_bit1", 32'(rgb1), 32'd0);
    check("inw_219_x2", 32'(inw1), 32'd1);
    step(217, 156, 1'b0, 1'b0);
    check("inw_c1_216", 32'(inw0), 32'd0);
    check("rgb_c1_216", 32'(rgb0), 32'd0);
    step(344, 155, 1'b0, 1'b0);
    check("inw_c1_345", 32'(inw0), 32'd0);
    step(343, 155, 1'b0, 1'b0);
    check("addr_last", 32'(rom_addr0), 32'd2047);
    check("inw_c2_27", 32'(inw0), 32'd0);
    step(472, 28, 1'b0, 1'b0);
    check("inw_c2_156", 32'(inw0), 32'd0);
    step(473, 28, 1'b0, 1'b0);
    check("rgb_last_bit7", 32'(rgb0), 32'd7);
    check("inw_last", 32'(inw0), 32'd1);
    step(0, 0, 1'b0, 1'b0);
    check("rgb_last_bit6", 32'(rgb0), 32'd0);
    check("inw_last_bit6", 32'(inw0), 32'd1);
    step(0, 0, 1'b0, 1'b0);
    check("inw_472_x2", 32'(inw1), 32'd1);
    step(0, 0, 1'b0, 1'b0);
    check("inw_473_x2", 32'(inw1), 32'd0);

    // Offset only takes effect at frame_start.
    x_off = 10'd10;
    step(217, 28, 1'b0, 1'b0);
    repeat (3) step(0, 0, 1'b0, 1'b0);
    check("xoff_unlatched_inw", 32'(inw0), 32'd1);
    check("xoff_unlatched_rgb", 32'(rgb0), 32'd7);
    step(0, 0, 1'b1, 1'b0);
    step(226, 28, 1'b0, 1'b0);
    step(227, 28, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    check("xoff_226_out", 32'(inw0), 32'd0);
    step(0, 0, 1'b0, 1'b0);
    check("xoff_227_in", 32'(inw0), 32'd1);
    check("xoff_227_rgb", 32'(rgb0), 32'd7);

    // Reset in the middle of an active line.
    x_off = 10'd0;
    step(0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(217 + i, 28, 1'b0, 1'b0);
    check("pre_rst_inw", 32'(inw0), 32'd1);
    step(223, 28, 1'b0, 1'b1);
    check("rst_mid_rgb", 32'(rgb0), 32'd0);
    check("rst_mid_inw", 32'(inw0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(217 + i, 28, 1'b0, 1'b0);
      check($sformatf("rel_blank%0d", i), 32'(inw0), 32'd0);
    end
    step(220, 28, 1'b0, 1'b0);
    check("rel_first_inw", 32'(inw0), 32'd1);
    check("rel_fg_cleared", 32'(rgb0), 32'd0);

    // Blink with BLINK_FRAMES=2, counting frames from reset.
    fg_color = 3'd5; bg_color = 3'd2; mode = 2'd2;
    for (int f = 1; f <= 5; f++) begin
      step(0, 0, 1'b1, 1'b0);
      step(217, 28, 1'b0, 1'b0);
      repeat (3) step(0, 0, 1'b0, 1'b0);
      check($sformatf("blink_frame%0d", f), 32'(rgb0), (f == 2 || f == 3) ? 32'd2 : 32'd5);
    end

    // Transparent mode.
    mode = 2'd3;
    step(0, 0, 1'b1, 1'b0);
    step(218, 28, 1'b0, 1'b0);
    step(217, 28, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    check("transp_pix0_rgb", 32'(rgb0), 32'd0);
    check("transp_pix0_inw", 32'(inw0), 32'd1);
    step(0, 0, 1'b0, 1'b0);
    check("transp_pix1_rgb", 32'(rgb0), 32'd5);

    // Random raster with random settings, frame pulses and rare resets.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(15) == 0) begin
        x_off    = 10'($urandom_range(40));
        y_off    = 10'($urandom_range(40));
        fg_color = 3'($urandom);
        bg_color = 3'($urandom);
        mode     = 2'($urandom);
      end
      step(int'($urandom_range(520, 200)), int'($urandom_range(320, 20)),
           $urandom_range(11) == 0, $urandom_range(499) == 0);
    end
    repeat (4) step(0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
